// File: rtl/muldiv_e.sv
// muldiv_e: iterative RV32M multiply/divide unit for the Execute stage (shift-add multiply, restoring divide).
// Optional macro MULDIV_EARLY_OUT_EN lets divide-by-zero, signed overflow and zero-operand multiplies skip CALC.
module muldiv_e #(
    parameter int XLEN = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_e_i,
    input  logic [2:0]        op_e_i,
    input  logic [XLEN-1:0]   src_a_e_i,
    input  logic [XLEN-1:0]   src_b_e_i,
    input  logic              flush_e_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [XLEN-1:0]   result_o
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CALC    = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;
    localparam logic [4:0] LAST_ITER = 5'd31;

    logic [1:0]  state_q,  state_d;
    logic [2:0]  op_q,     op_d;
    logic        neg_q,    neg_d;
    logic        rneg_q,   rneg_d;
    logic        div0_q,   div0_d;
    logic [4:0]  cnt_q,    cnt_d;
    logic [63:0] mcand_q,  mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [63:0] acc_q,    acc_d;
    logic        done_q,   done_d;
    logic [31:0] result_q, result_d;

    logic        sgn_a, sgn_b, neg_a, neg_b;
    logic [31:0] mag_a, mag_b;

    always_comb begin
        sgn_a = 1'b1;
        sgn_b = 1'b1;
        case (op_e_i)
            3'b010:                 sgn_b = 1'b0;
            3'b011, 3'b101, 3'b111: begin
                sgn_a = 1'b0;
                sgn_b = 1'b0;
            end
            default: ;
        endcase
        neg_a = sgn_a & src_a_e_i[31];
        neg_b = sgn_b & src_b_e_i[31];
        mag_a = neg_a ? (32'd0 - src_a_e_i) : src_a_e_i;
        mag_b = neg_b ? (32'd0 - src_b_e_i) : src_b_e_i;
    end

    // Divide reuses the registers: mcand[31:0] = divisor, mplier = dividend/quotient, acc = remainder.
    logic [63:0] acc_mul;
    logic [32:0] rem_sh, rem_new;
    logic [33:0] rem_diff;
    logic        q_bit;
    logic [31:0] quo_raw;
    logic [63:0] prod;
    logic [31:0] quo, rem, fin_res;

    always_comb begin
        acc_mul  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        rem_sh   = {acc_q[31:0], mplier_q[31]};
        rem_diff = {1'b0, rem_sh} - {2'b00, mcand_q[31:0]};
        q_bit    = ~rem_diff[33];
        rem_new  = q_bit ? rem_diff[32:0] : rem_sh;
        quo_raw  = {mplier_q[30:0], q_bit};
        prod     = neg_q ? (64'd0 - acc_mul) : acc_mul;
        quo      = div0_q ? 32'hFFFF_FFFF : (neg_q ? (32'd0 - quo_raw) : quo_raw);
        rem      = rneg_q ? (32'd0 - rem_new[31:0]) : rem_new[31:0];
        if (!op_q[2]) begin
            fin_res = (op_q[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
        end else begin
            fin_res = op_q[1] ? rem : quo;
        end
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic        early_hit;
    logic [31:0] early_res;

    always_comb begin
        early_hit = 1'b0;
        early_res = 32'd0;
        if (op_e_i[2] && (src_b_e_i == 32'd0)) begin
            early_hit = 1'b1;
            early_res = op_e_i[1] ? src_a_e_i : 32'hFFFF_FFFF;
        end else if (op_e_i[2] && !op_e_i[0] && (src_a_e_i == 32'h8000_0000)
                     && (src_b_e_i == 32'hFFFF_FFFF)) begin
            early_hit = 1'b1;
            early_res = op_e_i[1] ? 32'd0 : 32'h8000_0000;
        end else if (!op_e_i[2] && ((src_a_e_i == 32'd0) || (src_b_e_i == 32'd0))) begin
            early_hit = 1'b1;
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        div0_d   = div0_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        done_d   = 1'b0;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start_e_i) begin
                    op_d   = op_e_i;
                    neg_d  = neg_a ^ neg_b;
                    rneg_d = neg_a;
                    div0_d = op_e_i[2] & (src_b_e_i == 32'd0);
                    cnt_d  = 5'd0;
                    acc_d  = 64'd0;
                    if (op_e_i[2]) begin
                        mcand_d  = {32'd0, mag_b};
                        mplier_d = mag_a;
                    end else begin
                        mcand_d  = {32'd0, mag_a};
                        mplier_d = mag_b;
                    end
                    state_d = S_CALC;
`ifdef MULDIV_EARLY_OUT_EN
                    if (early_hit) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        result_d = early_res;
                    end
`endif
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + 5'd1;
                if (op_q[2]) begin
                    acc_d    = {31'd0, rem_new};
                    mplier_d = quo_raw;
                end else begin
                    acc_d    = acc_mul;
                    mcand_d  = {mcand_q[62:0], 1'b0};
                    mplier_d = {1'b0, mplier_q[31:1]};
                end
                if (cnt_q == LAST_ITER) begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    result_d = fin_res;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // A flushed instruction must leave no trace on the result path.
        if (flush_e_i) begin
            state_d  = S_IDLE;
            done_d   = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            op_q     <= 3'd0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
            cnt_q    <= 5'd0;
            mcand_q  <= 64'd0;
            mplier_q <= 32'd0;
            acc_q    <= 64'd0;
            done_q   <= 1'b0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            div0_q   <= div0_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy_o   = rst_ni & ~flush_e_i
                      & (((state_q == S_IDLE) & start_e_i) | (state_q == S_CALC));
    assign done_o   = done_q;
    assign result_o = result_q;
endmodule

// File: tb/tb_muldiv_e.sv
// Self-checking bench for muldiv_e: scoreboard of expected results, latency/busy/done/flush/reset checks.
module tb_muldiv_e;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a, src_b;
    logic        flush;
    logic        busy, done;
    logic [31:0] result;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_res = 32'd0;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = 33;
`endif

    always #5 clk = ~clk;

    muldiv_e dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .start_e_i (start),
        .op_e_i    (op),
        .src_a_e_i (src_a),
        .src_b_e_i (src_b),
        .flush_e_i (flush),
        .busy_o    (busy),
        .done_o    (done),
        .result_o  (result)
    );

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sp;
        logic [63:0]        ua, ub, up;
        logic               ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'b000: begin sp = sa * sb; return sp[31:0]; end
            3'b001: begin sp = sa * sb; return sp[63:32]; end
            3'b010: begin sp = sa * $signed(ub); return sp[63:32]; end
            3'b011: begin up = ua * ub; return up[63:32]; end
            3'b100: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            3'b101: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 32'd0) return a;
                if (ovf) return 32'd0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        bit sp;
        sp = (f[2] && b == 32'd0)
             || ((f == 3'b100 || f == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
             || (!f[2] && (a == 32'd0 || b == 32'd0));
        return sp ? EARLY_LAT : 33;
    endfunction

    // Called just after the edge into cycle 1; returns at the negedge of the done cycle.
    task automatic wait_done(output int lat, output bit seen, output bit busy_bad);
        lat      = 1;
        seen     = 1'b0;
        busy_bad = 1'b0;
        while (!seen && lat <= 40) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (busy !== 1'b1) busy_bad = 1'b1;
                @(posedge clk);
                lat++;
            end
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp_v;
        int          exp_lat, lat;
        bit          seen, busy_bad;
        exp_v   = ref_model(f, a, b);
        exp_lat = ref_lat(f, a, b);
        @(negedge clk);
        start = 1'b1; op = f; src_a = a; src_b = b;
        exp_q.push_back(exp_v);
        #1;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL %s busy_c0: got %b need 1", name, busy);
        end
        @(posedge clk); #1 start = 1'b0;
        wait_done(lat, seen, busy_bad);
        n_cmp++;
        if (!seen) begin
            n_bad++; $display("FAIL %s timeout: no done within 40 cycles", name);
            void'(exp_q.pop_front());
        end else begin
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (lat != exp_lat) begin
                n_bad++; $display("FAIL %s latency: got %0d need %0d", name, lat, exp_lat);
            end
            n_cmp++;
            if (busy !== 1'b0) begin
                n_bad++; $display("FAIL %s busy_done: got %b need 0", name, busy);
            end
            if (exp_lat > 1) begin
                n_cmp++;
                if (busy_bad) begin
                    n_bad++; $display("FAIL %s busy_calc: got a 0 need 1 through CALC", name);
                end
            end
            n_cmp++;
            if (result !== exp_v) begin
                n_bad++; $display("FAIL %s result: got %h need %h", name, result, exp_v);
            end
            last_res = exp_v;
            $display("op %-14s f=%b a=%h b=%h -> %h (lat %0d)", name, f, a, b, result, lat);
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0 || result !== exp_v) begin
                n_bad++; $display("FAIL %s pulse_hold: done=%b result=%h need done=0 result=%h",
                                  name, done, result, exp_v);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; op = 3'b000; src_a = 32'd1; src_b = 32'd1; flush = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            n_bad++; $display("FAIL reset_state: busy=%b done=%b result=%h need 0/0/0", busy, done, result);
        end
        start = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_mul();
        run_op("MUL", 3'b000, 32'd7, 32'hFFFF_FFFD);
        run_op("MULH", 3'b001, 32'h8000_0000, 32'h8000_0000);
        run_op("MULHU", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("MULHSU", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("MUL zero", 3'b000, 32'd0, 32'h1234_5678);
        run_op("MULH zero", 3'b001, 32'hDEAD_BEEF, 32'd0);
    endtask

    task automatic test_div();
        run_op("DIV", 3'b100, 32'hFFFF_FFF9, 32'd2);
        run_op("REM", 3'b110, 32'hFFFF_FFF9, 32'd2);
        run_op("DIVU", 3'b101, 32'd100, 32'd7);
        run_op("REMU", 3'b111, 32'd100, 32'd7);
        run_op("REM neg b", 3'b110, 32'd17, 32'hFFFF_FFFB);
    endtask

    task automatic test_div_special();
        run_op("DIV by 0", 3'b100, 32'd5, 32'd0);
        run_op("REM by 0", 3'b110, 32'd5, 32'd0);
        run_op("DIV neg by 0", 3'b100, 32'hFFFF_FFFB, 32'd0);
        run_op("REM neg by 0", 3'b110, 32'hFFFF_FFFB, 32'd0);
        run_op("DIVU by 0", 3'b101, 32'h8000_0001, 32'd0);
        run_op("DIV ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("REM ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
    endtask

    task automatic test_random();
        logic [2:0]  f;
        logic [31:0] a, b;
        for (int i = 0; i < 12; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = b >> $urandom_range(16, 31);
                default: ;
            endcase
            run_op("random", f, a, b);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e1, e2, got;
        int          lat;
        bit          seen, busy_bad;
        e1 = ref_model(3'b000, 32'd1234, 32'd5678);
        e2 = ref_model(3'b101, 32'd1000, 32'd33);
        @(negedge clk);
        start = 1'b1; op = 3'b000; src_a = 32'd1234; src_b = 32'd5678;
        exp_q.push_back(e1);
        @(posedge clk); #1;
        wait_done(lat, seen, busy_bad);
        n_cmp++;
        if (!seen || lat != 33) begin
            n_bad++; $display("FAIL b2b first_latency: got %0d (seen %b) need 33", lat, seen);
        end
        got = exp_q.pop_front();
        n_cmp++;
        if (busy !== 1'b0 || result !== got) begin
            n_bad++; $display("FAIL b2b first_done: busy=%b result=%h need busy=0 result=%h", busy, result, got);
        end
        @(posedge clk); #1;
        op = 3'b101; src_a = 32'd1000; src_b = 32'd33;
        exp_q.push_back(e2);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL b2b second_c0_busy: got %b need 1", busy);
        end
        @(posedge clk); #1 start = 1'b0;
        wait_done(lat, seen, busy_bad);
        n_cmp++;
        if (!seen || lat != 33) begin
            n_bad++; $display("FAIL b2b second_latency: got %0d (seen %b) need 33", lat, seen);
        end
        got = exp_q.pop_front();
        n_cmp++;
        if (result !== got) begin
            n_bad++; $display("FAIL b2b second_result: got %h need %h", result, got);
        end
        last_res = got;
        $display("op back-to-back MUL then DIVU -> %h", result);
        @(negedge clk);
    endtask

    task automatic test_flush();
        bit done_seen;
        done_seen = 1'b0;
        @(negedge clk);
        start = 1'b1; op = 3'b101; src_a = 32'd1000; src_b = 32'd7;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            @(negedge clk);
            if (done === 1'b1) done_seen = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        flush = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL flush busy: got %b need 0", busy);
        end
        @(posedge clk); #1 flush = 1'b0;
        if (done === 1'b1) done_seen = 1'b1;
        n_cmp++;
        if (done_seen) begin
            n_bad++; $display("FAIL flush done_pulse: got a done need none");
        end
        n_cmp++;
        if (result !== last_res) begin
            n_bad++; $display("FAIL flush result_kept: got %h need %h", result, last_res);
        end
        $display("op DIVU flushed in cycle 10");
        run_op("MUL after flush", 3'b000, 32'd6, 32'd7);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; op = 3'b000; src_a = 32'd3; src_b = 32'd5;
        @(posedge clk); #1 start = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            n_bad++; $display("FAIL reset_mid: busy=%b done=%b result=%h need 0/0/0", busy, done, result);
        end
        @(negedge clk); rst_n = 1'b1;
        last_res = 32'd0;
        $display("op MUL reset in cycle 15");
        run_op("MUL after reset", 3'b000, 32'hFFFF_FFFF, 32'd9);
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_special();
        test_random();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++; $display("FAIL scoreboard_empty: got %0d left need 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
